// File: rtl/ap_divmod_pkg.sv
// Shared types and sizing helpers for the ap_divmod iterative divider.
package ap_divmod_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Edges from the first rst=0 edge until ready rises on the iterative path.
    function automatic int unsigned divmod_latency(input int unsigned width);
        return width + 2;
    endfunction

    function automatic int unsigned divmod_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/ap_divmod_step.sv
// One combinational restoring-division step on a WIDTH+1 bit partial remainder.
module ap_divmod_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   prem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dvd_bit,
    output logic [WIDTH:0]   prem_next_c,
    output logic             q_bit_c
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] dvs_ext;

    always_comb begin
        shifted     = {prem, dvd_bit};
        dvs_ext     = {2'b00, divisor};
        q_bit_c     = (shifted >= dvs_ext);
        prem_next_c = q_bit_c ? (WIDTH+1)'(shifted - dvs_ext) : (WIDTH+1)'(shifted);
    end

endmodule

// File: rtl/ap_divmod.sv
// Iterative signed/unsigned divider with quotient, remainder and divide-by-zero flag.
// Define AP_DIVMOD_EARLY_EN to short-cut trivial operands straight from LOAD to FIX.
module ap_divmod
    import ap_divmod_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter bit          SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             ready
);

    localparam int unsigned CNT_W = divmod_cnt_w(WIDTH);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] dvd, dvd_nxt;
    logic [WIDTH-1:0] dvs, dvs_nxt;
    logic [WIDTH:0]   prem, prem_nxt;
    logic             neg_q, neg_q_nxt;
    logic             neg_r, neg_r_nxt;
    logic             zero, zero_nxt;
    logic [WIDTH-1:0] quotient_nxt, remainder_nxt;
    logic             div_by_zero_nxt, ready_nxt;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   step_prem;
    logic             step_q;

    // Operand magnitudes; most-negative maps onto its unsigned magnitude.
    always_comb begin
        a_neg = SIGNED && a[WIDTH-1];
        b_neg = SIGNED && b[WIDTH-1];
        a_mag = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag = b_neg ? (~b + WIDTH'(1)) : b;
    end

    // The dividend register shifts out its MSB and collects quotient bits at the LSB.
    ap_divmod_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .prem        (prem),
        .divisor     (dvs),
        .dvd_bit     (dvd[WIDTH-1]),
        .prem_next_c (step_prem),
        .q_bit_c     (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_LOAD;
            cnt         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            prem        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            ready       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            dvd         <= dvd_nxt;
            dvs         <= dvs_nxt;
            prem        <= prem_nxt;
            neg_q       <= neg_q_nxt;
            neg_r       <= neg_r_nxt;
            zero        <= zero_nxt;
            quotient    <= quotient_nxt;
            remainder   <= remainder_nxt;
            div_by_zero <= div_by_zero_nxt;
            ready       <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        dvd_nxt         = dvd;
        dvs_nxt         = dvs;
        prem_nxt        = prem;
        neg_q_nxt       = neg_q;
        neg_r_nxt       = neg_r;
        zero_nxt        = zero;
        quotient_nxt    = quotient;
        remainder_nxt   = remainder;
        div_by_zero_nxt = div_by_zero;
        ready_nxt       = ready;

        case (state)
            ST_LOAD: begin
                dvd_nxt   = a_mag;
                dvs_nxt   = b_mag;
                prem_nxt  = '0;
                neg_q_nxt = a_neg ^ b_neg;
                neg_r_nxt = a_neg;
                zero_nxt  = (b == '0);
                cnt_nxt   = CNT_W'(WIDTH);
                state_nxt = ST_ITER;
`ifdef AP_DIVMOD_EARLY_EN
                // Trivial operands: preload the magnitude results FIX expects.
                if (b_mag == '0) begin
                    dvd_nxt   = '1;
                    prem_nxt  = {1'b0, a_mag};
                    state_nxt = ST_FIX;
                end else if (b_mag == WIDTH'(1)) begin
                    dvd_nxt   = a_mag;
                    prem_nxt  = '0;
                    state_nxt = ST_FIX;
                end else if (a_mag < b_mag) begin
                    dvd_nxt   = '0;
                    prem_nxt  = {1'b0, a_mag};
                    state_nxt = ST_FIX;
                end
`endif
            end
            ST_ITER: begin
                dvd_nxt  = {dvd[WIDTH-2:0], step_q};
                prem_nxt = step_prem;
                cnt_nxt  = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                // Zero divisor: restoring steps leave |a| as remainder, so re-signing restores a.
                if (zero) begin
                    quotient_nxt = '1;
                end else begin
                    quotient_nxt = neg_q ? (~dvd + WIDTH'(1)) : dvd;
                end
                remainder_nxt   = neg_r ? (~prem[WIDTH-1:0] + WIDTH'(1)) : prem[WIDTH-1:0];
                div_by_zero_nxt = zero;
                ready_nxt       = 1'b1;
                state_nxt       = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_ap_divmod.sv
// Self-checking bench for ap_divmod across several WIDTH/SIGNED builds sharing one clock and reset.
module tb_ap_divmod;

`ifdef AP_DIVMOD_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;

    logic [31:0] q32s, r32s, q32u, r32u;
    logic [7:0]  q8u, r8u, q8s, r8s;
    logic [15:0] q16, r16;
    logic        z32s, z32u, z8u, z8s, z16;
    logic        rdy32s, rdy32u, rdy8u, rdy8s, rdy16;

    always #5 clk = ~clk;

    ap_divmod #(.WIDTH(32), .SIGNED(1'b1)) u32s (
        .clk(clk), .rst(rst), .a(a32), .b(b32),
        .quotient(q32s), .remainder(r32s), .div_by_zero(z32s), .ready(rdy32s));
    ap_divmod #(.WIDTH(32), .SIGNED(1'b0)) u32u (
        .clk(clk), .rst(rst), .a(a32), .b(b32),
        .quotient(q32u), .remainder(r32u), .div_by_zero(z32u), .ready(rdy32u));
    ap_divmod #(.WIDTH(8), .SIGNED(1'b0)) u8u (
        .clk(clk), .rst(rst), .a(a8), .b(b8),
        .quotient(q8u), .remainder(r8u), .div_by_zero(z8u), .ready(rdy8u));
    ap_divmod #(.WIDTH(8), .SIGNED(1'b1)) u8s (
        .clk(clk), .rst(rst), .a(a8), .b(b8),
        .quotient(q8s), .remainder(r8s), .div_by_zero(z8s), .ready(rdy8s));
    ap_divmod #(.WIDTH(16), .SIGNED(1'b1)) u16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16),
        .quotient(q16), .remainder(r16), .div_by_zero(z16), .ready(rdy16));

    int n_cmp = 0;
    int n_bad = 0;

    // Index order: 0=32s 1=32u 2=8u 3=8s 4=16s
    int          wid [5] = '{32, 32, 8, 8, 16};
    bit          sgn [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] ap_a [5], ap_b [5];
    logic [31:0] got_q [5], got_r [5];
    logic        got_z [5], got_rdy [5];
    int          lat [5];
    logic [31:0] eq [5], er [5];
    logic        ez [5];
    int          el [5];

    // Reference: plain 64-bit arithmetic on the operands interpreted per WIDTH/SIGNED.
    function automatic void ref_div(input int w, input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output logic z);
        longint mask, av, bv;
        mask = (longint'(1) << w) - 1;
        av = longint'(a) & mask;
        bv = longint'(b) & mask;
        if (s && (((av >> (w - 1)) & 1) != 0)) av = av - (longint'(1) << w);
        if (s && (((bv >> (w - 1)) & 1) != 0)) bv = bv - (longint'(1) << w);
        z = (bv == 0);
        if (z) begin
            q = 32'(mask);
            r = 32'(longint'(a) & mask);
        end else begin
            q = 32'((av / bv) & mask);
            r = 32'((av % bv) & mask);
        end
    endfunction

    function automatic int exp_lat(input int w, input bit s, input logic [31:0] a, input logic [31:0] b);
        longint mask, av, bv;
        bit early;
        mask = (longint'(1) << w) - 1;
        av = longint'(a) & mask;
        bv = longint'(b) & mask;
        if (s && (((av >> (w - 1)) & 1) != 0)) av = av - (longint'(1) << w);
        if (s && (((bv >> (w - 1)) & 1) != 0)) bv = bv - (longint'(1) << w);
        if (av < 0) av = -av;
        if (bv < 0) bv = -bv;
        early = (bv <= 1) || (av < bv);
        return (EARLY && early) ? 2 : w + 2;
    endfunction

    task automatic snapshot();
        got_q[0] = q32s;        got_r[0] = r32s;        got_z[0] = z32s; got_rdy[0] = rdy32s;
        got_q[1] = q32u;        got_r[1] = r32u;        got_z[1] = z32u; got_rdy[1] = rdy32u;
        got_q[2] = 32'(q8u);    got_r[2] = 32'(r8u);    got_z[2] = z8u;  got_rdy[2] = rdy8u;
        got_q[3] = 32'(q8s);    got_r[3] = 32'(r8s);    got_z[3] = z8s;  got_rdy[3] = rdy8s;
        got_q[4] = 32'(q16);    got_r[4] = 32'(r16);    got_z[4] = z16;  got_rdy[4] = rdy16;
    endtask

    // Pulse rst, launch one operation, scramble inputs after the LOAD edge, record ready latency.
    task automatic run_op();
        bit all_seen;
        ap_a[0] = a32;      ap_b[0] = b32;
        ap_a[1] = a32;      ap_b[1] = b32;
        ap_a[2] = 32'(a8);  ap_b[2] = 32'(b8);
        ap_a[3] = 32'(a8);  ap_b[3] = 32'(b8);
        ap_a[4] = 32'(a16); ap_b[4] = 32'(b16);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 5; k++) lat[k] = -1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                a32 = $urandom; b32 = $urandom;
                a8 = 8'($urandom); b8 = 8'($urandom);
                a16 = 16'($urandom); b16 = 16'($urandom);
            end
            snapshot();
            all_seen = 1'b1;
            for (int k = 0; k < 5; k++) begin
                if (lat[k] < 0 && got_rdy[k] === 1'b1) lat[k] = e;
                if (lat[k] < 0) all_seen = 1'b0;
            end
            if (all_seen) break;
        end
    endtask

    task automatic expect_all();
        for (int k = 0; k < 5; k++) begin
            ref_div(wid[k], sgn[k], ap_a[k], ap_b[k], eq[k], er[k], ez[k]);
            el[k] = exp_lat(wid[k], sgn[k], ap_a[k], ap_b[k]);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        snapshot();
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if ({got_q[k], got_r[k], got_z[k], got_rdy[k]} !== 66'd0) begin
                n_bad++;
                $display("FAIL reset_init[%0d] got q=%h r=%h z=%b rdy=%b, want all zero",
                         k, got_q[k], got_r[k], got_z[k], got_rdy[k]);
            end
        end
        a32 = 32'd100; b32 = 32'd7; a8 = 8'd50; b8 = 8'd3; a16 = 16'd9; b16 = 16'd4;
        run_op();
        // Hold rst over a finished result: everything clears and stays clear.
        @(negedge clk) rst = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk);
            #1;
            snapshot();
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if ({got_q[k], got_r[k], got_z[k], got_rdy[k]} !== 66'd0) begin
                    n_bad++;
                    $display("FAIL reset_hold[%0d] edge %0d got q=%h r=%h z=%b rdy=%b, want all zero",
                             k, e, got_q[k], got_r[k], got_z[k], got_rdy[k]);
                end
            end
        end
    endtask

    task automatic test_plan_vectors();
        a32 = 32'(-1234124124); b32 = 32'd134123;
        a8 = 8'd200; b8 = 8'd7;
        a16 = 16'd100; b16 = 16'd0;
        run_op();
        expect_all();
        eq[0] = 32'(-9201); er[0] = 32'(-58401); ez[0] = 1'b0; el[0] = 34;
        eq[2] = 32'd28;     er[2] = 32'd4;      ez[2] = 1'b0;
        eq[4] = 32'h0000_FFFF; er[4] = 32'd100; ez[4] = 1'b1; el[4] = EARLY ? 2 : 18;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (got_q[k] !== eq[k]) begin n_bad++; $display("FAIL plan_quot[%0d] got %h want %h", k, got_q[k], eq[k]); end
            n_cmp++;
            if (got_r[k] !== er[k]) begin n_bad++; $display("FAIL plan_rem[%0d] got %h want %h", k, got_r[k], er[k]); end
            n_cmp++;
            if (got_z[k] !== ez[k]) begin n_bad++; $display("FAIL plan_dbz[%0d] got %b want %b", k, got_z[k], ez[k]); end
            n_cmp++;
            if (lat[k] != el[k]) begin n_bad++; $display("FAIL plan_latency[%0d] got %0d want %0d", k, lat[k], el[k]); end
        end
    endtask

    task automatic test_boundary();
        logic [7:0] ta [6], tb [6], uq [6], ur [6], sq [6], sr [6];
        ta = '{8'hC8, 8'h03, 8'h80, 8'h07, 8'hF9, 8'h05};
        tb = '{8'h07, 8'h09, 8'hFF, 8'hFE, 8'h02, 8'h00};
        uq = '{8'h1C, 8'h00, 8'h00, 8'h00, 8'h7C, 8'hFF};
        ur = '{8'h04, 8'h03, 8'h80, 8'h07, 8'h01, 8'h05};
        sq = '{8'hF8, 8'h00, 8'h80, 8'hFD, 8'hFD, 8'hFF};
        sr = '{8'h00, 8'h03, 8'h00, 8'h01, 8'hFF, 8'h05};
        for (int i = 0; i < 6; i++) begin
            a8 = ta[i]; b8 = tb[i];
            a32 = (i == 2) ? 32'h8000_0000 : $urandom;
            b32 = (i == 2) ? 32'hFFFF_FFFF : ((i == 5) ? 32'd0 : $urandom);
            a16 = (i == 2) ? 16'h8000 : 16'($urandom);
            b16 = (i == 2) ? 16'hFFFF : 16'($urandom);
            run_op();
            expect_all();
            eq[2] = 32'(uq[i]); er[2] = 32'(ur[i]); ez[2] = (i == 5);
            eq[3] = 32'(sq[i]); er[3] = 32'(sr[i]); ez[3] = (i == 5);
            if (i == 2) begin
                eq[0] = 32'h8000_0000; er[0] = 32'd0; ez[0] = 1'b0;
                eq[4] = 32'h0000_8000; er[4] = 32'd0; ez[4] = 1'b0;
            end
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (got_q[k] !== eq[k]) begin n_bad++; $display("FAIL edge_quot row %0d[%0d] got %h want %h", i, k, got_q[k], eq[k]); end
                n_cmp++;
                if (got_r[k] !== er[k]) begin n_bad++; $display("FAIL edge_rem row %0d[%0d] got %h want %h", i, k, got_r[k], er[k]); end
                n_cmp++;
                if (got_z[k] !== ez[k]) begin n_bad++; $display("FAIL edge_dbz row %0d[%0d] got %b want %b", i, k, got_z[k], ez[k]); end
                n_cmp++;
                if (lat[k] != el[k]) begin n_bad++; $display("FAIL edge_latency row %0d[%0d] got %0d want %0d", i, k, lat[k], el[k]); end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int first;
        a32 = 32'd1000; b32 = 32'd3;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) begin rst = 1'b1; a32 = 32'd50; b32 = 32'd5; end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({q32s, r32s, z32s, rdy32s} !== 66'd0) begin
            n_bad++;
            $display("FAIL midop_clear got q=%h r=%h z=%b rdy=%b, want all zero", q32s, r32s, z32s, rdy32s);
        end
        @(negedge clk) rst = 1'b0;
        first = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin a32 = $urandom; b32 = $urandom; end
            if (rdy32s === 1'b1) begin first = e; break; end
        end
        n_cmp++;
        if (first != exp_lat(32, 1'b1, 32'd50, 32'd5)) begin
            n_bad++;
            $display("FAIL midop_latency got %0d want %0d", first, exp_lat(32, 1'b1, 32'd50, 32'd5));
        end
        n_cmp++;
        if (q32s !== 32'd10 || r32s !== 32'd0 || z32s !== 1'b0) begin
            n_bad++;
            $display("FAIL midop_result got q=%0d r=%0d z=%b want q=10 r=0 z=0", q32s, r32s, z32s);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            a32 = $urandom; b32 = $urandom;
            case ($urandom_range(0, 9))
                0: b32 = 32'd0;
                1: b32 = 32'd1;
                2: b32 = 32'hFFFF_FFFF;
                3: a32 = 32'h8000_0000;
                4: a32 = a32 >> $urandom_range(1, 31);
                5: b32 = b32 >> $urandom_range(8, 31);
                default: ;
            endcase
            a8 = 8'($urandom); b8 = 8'($urandom);
            if ($urandom_range(0, 7) == 0) b8 = 8'd0;
            a16 = 16'($urandom);
            b16 = 16'($urandom) >> $urandom_range(0, 15);
            run_op();
            expect_all();
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (got_q[k] !== eq[k] || got_r[k] !== er[k] || got_z[k] !== ez[k]) begin
                    n_bad++;
                    $display("FAIL rand_result[%0d] a=%h b=%h got q=%h r=%h z=%b want q=%h r=%h z=%b",
                             k, ap_a[k], ap_b[k], got_q[k], got_r[k], got_z[k], eq[k], er[k], ez[k]);
                end
                n_cmp++;
                if (lat[k] != el[k] || got_rdy[k] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rand_latency[%0d] a=%h b=%h got %0d (rdy=%b) want %0d",
                             k, ap_a[k], ap_b[k], lat[k], got_rdy[k], el[k]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        test_reset();
        test_plan_vectors();
        test_boundary();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
